// File: rtl/iob_fir_interp2.sv
// 2x interpolating polyphase FIR with one time-shared multiplier.
// Each accepted sample yields a phase-0 then a phase-1 output.
module iob_fir_interp2 #(
  parameter int DATA_IN_W  = 8,
  parameter int DATA_OUT_W = 8,
  parameter int COEFF_W    = 8,
  parameter int TAPS       = 16,
  parameter int TAPS_W     = 4,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_IN_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_OUT_W-1:0] out_data,
  input  logic                  coeff_we,
  input  logic [TAPS_W:0]       coeff_addr,
  input  logic [COEFF_W-1:0]    coeff_din,
  output logic                  busy
);

  localparam int PW = DATA_IN_W + COEFF_W;
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [ACC_W:0] OMAX = ((ACC_W+1)'(1) <<< (DATA_OUT_W-1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] OMIN = -((ACC_W+1)'(1) <<< (DATA_OUT_W-1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_IN_W-1:0] x [TAPS];
  logic signed [COEFF_W-1:0]   c [2*TAPS];
  logic signed [ACC_W-1:0]     acc;
  logic [TAPS_W-1:0]           k;
  logic                        ph;
  logic                        fin;

  logic signed [PW-1:0]         xa, ca, prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W:0]        acc_ext, rnd;
  logic signed [DATA_OUT_W-1:0] sat;

  assign xa       = PW'(x[k]);
  assign ca       = PW'(c[{ph, k}]);
  assign prod     = xa * ca;
  assign prod_ext = ACC_W'(prod);

  // Round half up, then clamp to the output range; one extra bit keeps the
  // rounding add from wrapping near the accumulator limits.
  assign acc_ext = {acc[ACC_W-1], acc};
  assign rnd     = (acc_ext + HALF) >>> SHIFT;

  always_comb begin
    sat = rnd[DATA_OUT_W-1:0];
    if (rnd > OMAX)
      sat = OMAX[DATA_OUT_W-1:0];
    else if (rnd < OMIN)
      sat = OMIN[DATA_OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MAC;
      MAC:  if (fin) state_nxt = OUT;
      OUT:  if (out_valid && out_ready) state_nxt = ph ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // fin marks that the last tap has been accumulated, giving MAC one extra
  // cycle in which the finished sum is rounded into out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      for (int i = 0; i < 2*TAPS; i++) c[i] <= '0;
      acc       <= '0;
      k         <= '0;
      ph        <= 1'b0;
      fin       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coeff_we)
            c[coeff_addr] <= coeff_din;
          if (in_valid) begin
            for (int j = TAPS-1; j > 0; j--) x[j] <= x[j-1];
            x[0] <= in_data;
            acc  <= '0;
            k    <= '0;
            ph   <= 1'b0;
            fin  <= 1'b0;
          end
        end
        MAC: begin
          if (!fin) begin
            acc <= acc + prod_ext;
            k   <= k + TAPS_W'(1);
            if (k == TAPS_W'(TAPS-1))
              fin <= 1'b1;
          end else begin
            out_data  <= sat;
            out_valid <= 1'b1;
            fin       <= 1'b0;
          end
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (!ph) begin
              ph  <= 1'b1;
              acc <= '0;
              k   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_fir_interp2.sv
// Directed bench for iob_fir_interp2: a sum-of-products reference model feeds
// an expected-output queue checked on every output handshake.
module tb_iob_fir_interp2;

  localparam int TAPS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              coeff_we;
  logic [4:0]        coeff_addr;
  logic [7:0]        coeff_din;
  logic              busy;

  iob_fir_interp2 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_din  (coeff_din),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int accept_cyc = 0;
  int m_x [TAPS];
  int m_c [2*TAPS];
  int exp_q [$];
  int got_q [$];

  task automatic check_output(string name, int actual, int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Output for one phase computed directly from the filter definition.
  function automatic int model_out(int ph);
    int s = 0;
    int r;
    for (int i = 0; i < TAPS; i++) s += m_x[i] * m_c[ph*TAPS + i];
    r = (s + 32) >>> 6;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic int sext8(int v);
    logic signed [7:0] b;
    b = v[7:0];
    return int'(b);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      if (exp_q.size() == 0)
        check_output("unexpected output", int'(out_data), 9999);
      else
        check_output("stream", int'(out_data), exp_q.pop_front());
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("in_ready timeout", int'(in_ready), 1);
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_output(name, int'(out_valid), 1);
  endtask

  task automatic apply_stimulus(int sample, bit we = 1'b0, int addr = 0, int din = 0);
    wait_ready();
    in_valid   = 1'b1;
    in_data    = sample[7:0];
    coeff_we   = we;
    coeff_addr = addr[4:0];
    coeff_din  = din[7:0];
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid   = 1'b0;
    coeff_we   = 1'b0;
    if (we) m_c[addr] = sext8(din);
    for (int j = TAPS-1; j > 0; j--) m_x[j] = m_x[j-1];
    m_x[0] = sext8(sample);
    exp_q.push_back(model_out(0));
    exp_q.push_back(model_out(1));
  endtask

  task automatic write_coeff(int addr, int val);
    wait_ready();
    coeff_we   = 1'b1;
    coeff_addr = addr[4:0];
    coeff_din  = val[7:0];
    @(posedge clk);
    @(negedge clk);
    coeff_we   = 1'b0;
    m_c[addr]  = sext8(val);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_output("drain timeout", exp_q.size(), 0);
  endtask

  task automatic run_impulse();
    repeat (15) apply_stimulus(0);
    drain();
    got_q.delete();
    apply_stimulus(64);
    repeat (15) apply_stimulus(0);
    drain();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coeff_we = 1'b0; coeff_addr = '0; coeff_din = '0;
    for (int i = 0; i < TAPS; i++) m_x[i] = 0;
    for (int i = 0; i < 2*TAPS; i++) m_c[i] = 0;
    repeat (3) @(negedge clk);
    check_output("reset in_ready", int'(in_ready), 1);
    check_output("reset busy", int'(busy), 0);
    check_output("reset out_valid", int'(out_valid), 0);
    check_output("reset out_data", int'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // Unity passthrough plus latency of both phases.
    write_coeff(0, 64);
    write_coeff(16, 32);
    got_q.delete();
    apply_stimulus(127);
    wait_valid("phase0 valid timeout");
    check_output("phase0 latency", cyc - accept_cyc, 17);
    @(negedge clk);
    wait_valid("phase1 valid timeout");
    check_output("phase1 latency", cyc - accept_cyc, 35);
    check_output("in_ready during phase1", int'(in_ready), 0);
    @(negedge clk);
    check_output("in_ready after phase1", int'(in_ready), 1);
    drain();
    check_output("unity phase0", got_q[0], 127);
    check_output("unity phase1", got_q[1], 64);

    // Impulse response reproduces the coefficient pairs.
    for (int i = 0; i < TAPS; i++) begin
      write_coeff(i, i);
      write_coeff(16 + i, -i);
    end
    run_impulse();
    for (int i = 0; i < TAPS; i++) begin
      check_output("impulse phase0", got_q[2*i], i);
      check_output("impulse phase1", got_q[2*i+1], -i);
    end

    // Back-pressure: output held, coefficient write dropped.
    out_ready = 1'b0;
    apply_stimulus(50);
    wait_valid("bp valid timeout");
    for (int i = 0; i < 10; i++) begin
      check_output("bp out_valid", int'(out_valid), 1);
      check_output("bp out_data", int'(out_data), exp_q[0]);
      check_output("bp in_ready", int'(in_ready), 0);
      check_output("bp busy", int'(busy), 1);
      coeff_we   = (i == 3);
      coeff_addr = 5'd1;
      coeff_din  = 8'd99;
      @(negedge clk);
    end
    coeff_we  = 1'b0;
    out_ready = 1'b1;
    drain();
    run_impulse();
    check_output("coeff after bp phase0", got_q[2], 1);
    check_output("coeff after bp phase1", got_q[3], -1);

    // Saturation at both rails.
    for (int a = 0; a < 2*TAPS; a++) write_coeff(a, 127);
    repeat (16) apply_stimulus(127);
    drain();
    check_output("sat high phase0", got_q[$-1], 127);
    check_output("sat high phase1", got_q[$], 127);
    repeat (16) apply_stimulus(-128);
    drain();
    check_output("sat low phase0", got_q[$-1], -128);
    check_output("sat low phase1", got_q[$], -128);

    // Reset in the middle of phase-0 MAC.
    apply_stimulus(5);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst out_valid", int'(out_valid), 0);
    check_output("midrst in_ready", int'(in_ready), 1);
    check_output("midrst busy", int'(busy), 0);
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) m_x[i] = 0;
    for (int i = 0; i < 2*TAPS; i++) m_c[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    apply_stimulus(64);
    drain();
    check_output("post-reset phase0", got_q[0], 0);
    check_output("post-reset phase1", got_q[1], 0);

    // Coefficient write and sample accepted on the same edge.
    got_q.delete();
    apply_stimulus(10, 1'b1, 0, 64);
    drain();
    check_output("same-edge phase0", got_q[0], 10);
    check_output("same-edge phase1", got_q[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
